// File: rtl/fft_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : fft_input_loader
// Description : Collects one frame of real samples at bit-reversed addresses
//               and hands it to the FFT core. Optional macro
//               FFT_LOADER_PINGPONG_EN adds a second bank so that filling
//               continues while the core owns the other bank.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_input_loader #(
  parameter int N_POINTS = 8,
  parameter int LOG2N    = 3,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              frame_valid,
  input  logic              frame_take,
  input  logic              frame_release,
  input  logic [LOG2N-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [LOG2N:0]    fill_count,
  output logic              overrun
);

  localparam logic [1:0]     C_FILL     = 2'd0;
  localparam logic [1:0]     C_FULL     = 2'd1;
  localparam logic [1:0]     C_BUSY     = 2'd2;
  localparam logic [LOG2N:0] C_FULL_CNT = (LOG2N+1)'(N_POINTS);

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [LOG2N:0]   fill_count_q, fill_count_d;
  logic             overrun_q, overrun_d;

  logic             w_xfer;
  logic [LOG2N:0]   w_cnt_inc;
  logic [LOG2N:0]   w_cnt_after;
  logic [LOG2N-1:0] w_wr_addr;

  assign w_xfer      = sample_valid && sample_ready;
  assign w_cnt_inc   = fill_count_q + 1'b1;
  assign w_cnt_after = w_xfer ? w_cnt_inc : fill_count_q;
  assign w_wr_addr   = bitrev(fill_count_q[LOG2N-1:0]);

  assign frame_valid = (state_q == C_FULL);
  assign fill_count  = fill_count_q;
  assign overrun     = overrun_q;

`ifdef FFT_LOADER_PINGPONG_EN

  // core_bank_q selects the bank the core reads; the other bank is filled.
  logic                core_bank_q, core_bank_d;
  logic                w_fill_bank;
  logic [DATA_W-1:0]   mem_q [2][N_POINTS];

  assign w_fill_bank  = ~core_bank_q;
  assign sample_ready = (fill_count_q != C_FULL_CNT);
  assign rd_data      = mem_q[core_bank_q][rd_addr];

  always_comb begin
    state_d      = state_q;
    fill_count_d = w_cnt_after;
    overrun_d    = overrun_q;
    core_bank_d  = core_bank_q;
    case (state_q)
      C_FILL: begin
        if (w_cnt_after == C_FULL_CNT) begin
          state_d      = C_FULL;
          core_bank_d  = ~core_bank_q;
          fill_count_d = '0;
        end
      end
      C_FULL: begin
        if (frame_take) begin
          state_d = C_BUSY;
        end
      end
      C_BUSY: begin
        if (sample_valid && !sample_ready) begin
          overrun_d = 1'b1;
        end
        if (frame_release) begin
          // A bank that completed during BUSY is presented straight away.
          if (w_cnt_after == C_FULL_CNT) begin
            state_d      = C_FULL;
            core_bank_d  = ~core_bank_q;
            fill_count_d = '0;
          end else begin
            state_d = C_FILL;
          end
        end
      end
      default: begin
        state_d      = C_FILL;
        fill_count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_bank_q <= 1'b0;
    end else begin
      core_bank_q <= core_bank_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer) begin
      mem_q[w_fill_bank][w_wr_addr] <= sample_in;
    end
  end

`else

  logic [DATA_W-1:0] mem_q [N_POINTS];

  assign sample_ready = (state_q == C_FILL);
  assign rd_data      = mem_q[rd_addr];

  always_comb begin
    state_d      = state_q;
    fill_count_d = fill_count_q;
    overrun_d    = overrun_q;
    case (state_q)
      C_FILL: begin
        fill_count_d = w_cnt_after;
        if (w_cnt_after == C_FULL_CNT) begin
          state_d = C_FULL;
        end
      end
      C_FULL: begin
        // Samples offered here are ordinary backpressure, not an overrun.
        if (frame_take) begin
          state_d = C_BUSY;
        end
      end
      C_BUSY: begin
        if (sample_valid && !sample_ready) begin
          overrun_d = 1'b1;
        end
        if (frame_release) begin
          state_d      = C_FILL;
          fill_count_d = '0;
        end
      end
      default: begin
        state_d      = C_FILL;
        fill_count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_xfer) begin
      mem_q[w_wr_addr] <= sample_in;
    end
  end

`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= C_FILL;
      fill_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_count_q <= fill_count_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule
`default_nettype wire
